wb_arbiter_2to1: RTL
====================

# wb_arbiter_2to1

Two-master Wishbone B4 pipelined arbiter sharing the single RAM device port between the core's instruction-fetch master (m0) and its load/store master (m1). It sits between the core and the memory wrapper. It holds a registered grant for the whole bus cycle and tracks outstanding requests so every ack is routed to the master that issued it. Arbitration is round-robin or fixed-priority.

## Interface
- FIXED_PRIO, 0, 0 = round-robin between m0/m1; 1 = m0 always wins contested arbitration
- MAX_OUTSTANDING, 4, max accepted-but-unacked requests per grant; counter width = $clog2(MAX_OUTSTANDING+1)
- i_clk  in  1  clock, all state on rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_m0_wb_cyc / i_m0_wb_stb / i_m0_wb_we  in  1 each  master 0 cycle, strobe, write enable
- i_m0_wb_addr / i_m0_wb_data  in  32 each  master 0 address, write data
- i_m0_wb_sel  in  4  master 0 byte select
- o_m0_wb_ack / o_m0_wb_stall  out  1 each  master 0 ack, stall
- o_m0_wb_data  out  32  master 0 read data
- i_m1_wb_*, o_m1_wb_*  same set and widths as m0, for master 1
- o_s_wb_cyc / o_s_wb_stb / o_s_wb_we  out  1 each  to RAM port
- o_s_wb_addr / o_s_wb_data  out  32 each  to RAM port
- o_s_wb_sel  out  4  to RAM port
- i_s_wb_ack / i_s_wb_stall  in  1 each  from RAM port
- i_s_wb_data  in  32  from RAM port

## Operation
- States: IDLE, GNT0, GNT1 (registered). Registers: last_grant (1 b), outstanding counter cnt.
- IDLE: slave outputs all 0; both masters see stall=1, ack=0, data=0.
- IDLE arbitration: only m0 cyc -> GNT0; only m1 cyc -> GNT1. Both: FIXED_PRIO=1 -> GNT0; FIXED_PRIO=0 -> master != last_grant. On entering GNTx, last_grant <= x, cnt <= 0.
- GNTx: o_s_wb_{cyc,stb,we,addr,data,sel} = master x inputs. o_mx_wb_stall = i_s_wb_stall | (cnt == MAX_OUTSTANDING). o_s_wb_stb = i_mx_wb_stb & (cnt != MAX_OUTSTANDING). o_mx_wb_ack = i_s_wb_ack & (cnt != 0); o_mx_wb_data = i_s_wb_data. Non-granted master: stall=1, ack=0, data=0.
- cnt: +1 on accept (o_s_wb_stb & ~i_s_wb_stall); -1 on forwarded ack; both in one cycle -> unchanged. Never wraps. A stray ack with cnt=0 is dropped, not forwarded.
- Release from GNTx: (a) i_mx_wb_cyc=0; outstanding acks are abandoned per Wishbone, cnt <= 0. (b) Idle point: i_mx_wb_stb=0, cnt=0, other master cyc=1 -> preempt.
- On release, go to GNTy if the other master's cyc=1, else IDLE. This is a one-cycle handover with no IDLE bubble.
- Reset (any time, including mid-transfer): state IDLE, cnt 0, last_grant 1, so m0 wins first contested round-robin.

## Timing
- Reset values: o_s_wb_* all 0; o_m0/o_m1 ack 0, stall 1, data 0.
- Grant latency: cyc raised in IDLE at cycle N -> GNTx at N+1; slave sees stb at N+1.
- Data path is combinational in GNTx: slave stall/ack/data reach the granted master in the same cycle. Master request fields reach the slave in the same cycle.
- Handover: granted master drops cyc at N; o_s_wb_cyc=0 at N (combinational); other master granted at N+1.
- cnt == MAX_OUTSTANDING: stall forced and slave stb masked the same cycle. Both clear the cycle after the next ack.

## Test plan
- Reset mid-transfer: assert i_rst_n=0 while GNT1 with cnt=2 -> same cycle o_s_wb_cyc=0, o_m1_wb_stall=1, o_m1_wb_ack=0; after release, m0 and m1 request together -> GNT0.
- Single m0 read: cyc/stb at N, addr 0x100, RAM no stall, ack at N+2 with data 0xDEADBEEF -> slave stb at N+1, o_m0_wb_ack=1 and o_m0_wb_data=0xDEADBEEF at N+2, m1 stall=1 throughout.
- Round-robin contention (FIXED_PRIO=0): both hold cyc for repeated single transfers, each dropping cyc after its ack -> grants alternate m0, m1, m0, m1 with one-cycle handover; FIXED_PRIO=1 -> m0 every contested round.
- Outstanding limit (MAX_OUTSTANDING=4): m1 streams 6 stb with RAM ack delayed 5 cycles -> exactly 4 accepted, then o_m1_wb_stall=1 and o_s_wb_stb=0 until first ack; all 6 acks reach m1 in order.
- Preemption and stray ack: m0 holds cyc with stb=0, cnt=0, while m1 requests -> GNT1 next cycle. An i_s_wb_ack injected with cnt=0 -> neither master sees ack, cnt stays 0.

Source files
------------

// File: rtl/wb_arbiter_2to1.sv
// -----------------------------------------------------------------------------
// wb_arbiter_2to1
//   Two-master Wishbone B4 pipelined arbiter. Master 0 (instruction fetch) and
//   master 1 (load/store) share one RAM slave port. A grant is registered and
//   held for the whole bus cycle. An outstanding-request counter makes sure
//   acks are only forwarded for requests the granted master actually issued.
//
// Parameters
//   FIXED_PRIO       0: round-robin on contested IDLE arbitration, 1: m0 wins
//   MAX_OUTSTANDING  accepted-but-unacked requests allowed per grant
//
// Ports
//   i_clk, i_rst_n               clock, async active-low reset
//   i_m{0,1}_wb_*                master request: cyc, stb, we, addr, data, sel
//   o_m{0,1}_wb_*                master response: ack, stall, data
//   o_s_wb_*                     slave request: cyc, stb, we, addr, data, sel
//   i_s_wb_*                     slave response: ack, stall, data
// -----------------------------------------------------------------------------
module wb_arbiter_2to1 #(
    parameter int FIXED_PRIO      = 0,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,

    input  logic        i_m0_wb_cyc,
    input  logic        i_m0_wb_stb,
    input  logic        i_m0_wb_we,
    input  logic [31:0] i_m0_wb_addr,
    input  logic [31:0] i_m0_wb_data,
    input  logic [3:0]  i_m0_wb_sel,
    output logic        o_m0_wb_ack,
    output logic        o_m0_wb_stall,
    output logic [31:0] o_m0_wb_data,

    input  logic        i_m1_wb_cyc,
    input  logic        i_m1_wb_stb,
    input  logic        i_m1_wb_we,
    input  logic [31:0] i_m1_wb_addr,
    input  logic [31:0] i_m1_wb_data,
    input  logic [3:0]  i_m1_wb_sel,
    output logic        o_m1_wb_ack,
    output logic        o_m1_wb_stall,
    output logic [31:0] o_m1_wb_data,

    output logic        o_s_wb_cyc,
    output logic        o_s_wb_stb,
    output logic        o_s_wb_we,
    output logic [31:0] o_s_wb_addr,
    output logic [31:0] o_s_wb_data,
    output logic [3:0]  o_s_wb_sel,
    input  logic        i_s_wb_ack,
    input  logic        i_s_wb_stall,
    input  logic [31:0] i_s_wb_data
);

    localparam int            CW      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
    } wb_req_t;

    state_t        state;
    logic          last_grant;   // 1 = m1 held the previous grant
    logic [CW-1:0] cnt;

    wb_req_t m0_req, m1_req, own_req;
    logic    other_cyc, granted, at_max, accept, ack_fwd, release_gnt;

    assign m0_req = '{i_m0_wb_cyc, i_m0_wb_stb, i_m0_wb_we, i_m0_wb_addr, i_m0_wb_data, i_m0_wb_sel};
    assign m1_req = '{i_m1_wb_cyc, i_m1_wb_stb, i_m1_wb_we, i_m1_wb_addr, i_m1_wb_data, i_m1_wb_sel};

    always_comb begin
        own_req   = (state == GNT1) ? m1_req : m0_req;
        other_cyc = (state == GNT1) ? i_m0_wb_cyc : i_m1_wb_cyc;
    end

    assign granted = (state == GNT0) || (state == GNT1);
    assign at_max  = (cnt == CNT_MAX);

    // Request path: granted master straight through; stb masked at the limit.
    assign o_s_wb_cyc  = granted & own_req.cyc;
    assign o_s_wb_stb  = granted & own_req.stb & ~at_max;
    assign o_s_wb_we   = granted & own_req.we;
    assign o_s_wb_addr = granted ? own_req.addr : '0;
    assign o_s_wb_data = granted ? own_req.data : '0;
    assign o_s_wb_sel  = granted ? own_req.sel  : '0;

    assign accept  = o_s_wb_stb & ~i_s_wb_stall;
    // An ack with nothing outstanding belongs to an abandoned cycle: drop it.
    assign ack_fwd = granted & i_s_wb_ack & (cnt != '0);

    // Release on cyc drop, or at an idle point when the other master waits.
    assign release_gnt = granted & (~own_req.cyc | (~own_req.stb & (cnt == '0) & other_cyc));

    // Response path: only the granted master sees the slave.
    assign o_m0_wb_stall = (state == GNT0) ? (i_s_wb_stall | at_max) : 1'b1;
    assign o_m0_wb_ack   = (state == GNT0) & ack_fwd;
    assign o_m0_wb_data  = (state == GNT0) ? i_s_wb_data : '0;
    assign o_m1_wb_stall = (state == GNT1) ? (i_s_wb_stall | at_max) : 1'b1;
    assign o_m1_wb_ack   = (state == GNT1) & ack_fwd;
    assign o_m1_wb_data  = (state == GNT1) ? i_s_wb_data : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    // m0 wins if alone, under fixed priority, or if m1 went last.
                    if (i_m0_wb_cyc & (~i_m1_wb_cyc | (FIXED_PRIO != 0) | last_grant)) begin
                        state      <= GNT0;
                        last_grant <= 1'b0;
                        cnt        <= '0;
                    end else if (i_m1_wb_cyc) begin
                        state      <= GNT1;
                        last_grant <= 1'b1;
                        cnt        <= '0;
                    end
                end
                GNT0, GNT1: begin
                    if (release_gnt) begin
                        cnt <= '0;
                        if (other_cyc) begin
                            // Direct handover, no IDLE bubble.
                            state      <= (state == GNT0) ? GNT1 : GNT0;
                            last_grant <= (state == GNT0);
                        end else begin
                            state <= IDLE;
                        end
                    end else if (accept & ~ack_fwd) begin
                        cnt <= cnt + 1'b1;
                    end else if (ack_fwd & ~accept) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
